serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on the clk rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, unsigned, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, unsigned, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN or DONE state).
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: final borrow, equal to 1 iff a < b.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE, registered on clk.
REQ-012 IDLE: start=1 at an edge SHALL latch a and b into internal shift registers, clear the internal borrow flop, clear the bit counter and move to RUN.
REQ-013 IDLE: start=0 SHALL keep the FSM in IDLE.
REQ-014 RUN: each edge SHALL process one bit LSB-first using d = a0 ^ b0 ^ br and br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-015 RUN: on each edge the block SHALL shift d into the internal result register from the MSB side, shift both operand registers right by one, and increment the counter.
REQ-016 RUN: on the edge that processes bit WIDTH-1, the block SHALL load diff with the completed result, load borrow_out with br_next, and move to DONE.
REQ-017 DONE: done SHALL be 1 for exactly this one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge 0, done SHALL be high in the cycle following edge WIDTH (for example, after edge 8 when WIDTH=8).
REQ-019 A new start SHALL be accepted no earlier than the edge that leaves DONE, giving a throughput of one operation per WIDTH+2 cycles.
REQ-020 start SHALL be ignored in RUN and DONE; a held or repeated start SHALL NOT restart, extend or corrupt the operation in progress.
REQ-021 After an accepted start, changes on a or b SHALL NOT affect the operation in progress.
REQ-022 diff and borrow_out SHALL hold their last result until the next completion and SHALL NOT show partial results during RUN.
REQ-023 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-024 Boundary: a == b SHALL give diff=0 and borrow_out=0; a=0 with b=1 SHALL give diff=all ones and borrow_out=1.
REQ-025 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap while in RUN.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and at any time, force the FSM to IDLE and set busy=0, done=0, diff=0, borrow_out=0, and clear all internal registers.
REQ-027 Reset asserted during RUN SHALL abort the operation with no done pulse, leaving outputs at their reset values.
REQ-028 After rst_n is released, the first start SHALL be accepted on the first rising edge at which rst_n is high.

Verification (WIDTH=8)
REQ-029 The bench SHALL apply a=0x05, b=0x03 with a one-cycle start and check that done pulses exactly once, in the 9th cycle after the accepting edge, with diff=0x02 and borrow_out=0.
REQ-030 The bench SHALL apply a=0x03, b=0x05 and check diff=0xFE and borrow_out=1; it SHALL apply a=0x00, b=0x01 and check diff=0xFF and borrow_out=1.
REQ-031 The bench SHALL apply a=0xA5, b=0xA5 and check diff=0x00 and borrow_out=0, with busy high for exactly 9 cycles.
REQ-032 The bench SHALL apply a=0xFF, b=0x01 with start held high for 20 cycles and check that result 0xFE with borrow_out=0 comes with one done pulse per operation, that a second operation starts only after DONE, and that a and b changed mid-RUN are ignored.
REQ-033 The bench SHALL start a=0x80, b=0x01 and assert rst_n=0 after 4 cycles, then check that busy, done, diff and borrow_out go to 0 immediately and that no done pulse follows.
REQ-034 The bench SHALL run all 65536 (a, b) pairs back-to-back and compare diff and borrow_out against the 9-bit value {1'b0,a} - {1'b0,b}.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one bit per clock, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // One extra counter bit so the post-increment value WIDTH never wraps.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             bit_diff;
  logic             br_next;
  logic             last_bit;

  assign bit_diff = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Result bits enter from the MSB side so the word is aligned after WIDTH shifts.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          res_d = '0;
          br_d  = 1'b0;
          cnt_d = '0;
        end
      end
      S_RUN: begin
        res_d = {bit_diff, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d   = {bit_diff, res_q[WIDTH-1:1]};
          borrow_d = br_next;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int LANES = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  logic         xs;
  logic [W-1:0] xa    [LANES];
  logic [W-1:0] xb    [LANES];
  logic         xbusy [LANES];
  logic         xdone [LANES];
  logic [W-1:0] xdiff [LANES];
  logic         xbor  [LANES];

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  // Parallel copies split the exhaustive sweep into 16 back-to-back streams.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    serial_subtractor #(.WIDTH(W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (xs),
      .a          (xa[g]),
      .b          (xb[g]),
      .busy       (xbusy[g]),
      .done       (xdone[g]),
      .diff       (xdiff[g]),
      .borrow_out (xbor[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation from IDLE and observes it for 15 cycles; a and b are
  // scrambled after the accepting edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int pulses, output int done_k, output int busy_n,
                       output logic [W-1:0] d_o, output logic b_o, output bit partial);
    logic [W-1:0] prev;
    prev    = diff;
    pulses  = 0;
    done_k  = -1;
    busy_n  = 0;
    d_o     = '0;
    b_o     = 1'b0;
    partial = 1'b0;
    a       = av;
    b       = bv;
    start   = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        pulses++;
        if (done_k < 0) begin
          done_k = k;
          d_o    = diff;
          b_o    = borrow_out;
        end
      end else if (pulses == 0 && diff !== prev) begin
        partial = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    xs    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      xa[l] = '0;
      xb[l] = '0;
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff got=%h exp=00", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_bad++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
  endtask

  task automatic test_basic;
    int pulses, done_k, busy_n;
    logic [W-1:0] d;
    logic br;
    bit partial;
    rst_n = 1'b1;
    do_op(8'h05, 8'h03, pulses, done_k, busy_n, d, br, partial);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (done_k !== 8) begin n_bad++; $display("FAIL basic_latency got=%0d exp=8", done_k); end
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL basic_diff got=%h exp=02", d); end
    n_cmp++; if (br !== 1'b0) begin n_bad++; $display("FAIL basic_borrow got=%b exp=0", br); end
    n_cmp++; if (partial !== 1'b0) begin n_bad++; $display("FAIL basic_partial got=%b exp=0", partial); end
  endtask

  task automatic test_borrow;
    int pulses, done_k, busy_n;
    logic [W-1:0] d;
    logic br;
    bit partial;
    do_op(8'h03, 8'h05, pulses, done_k, busy_n, d, br, partial);
    n_cmp++; if (d !== 8'hFE) begin n_bad++; $display("FAIL borrow35_diff got=%h exp=fe", d); end
    n_cmp++; if (br !== 1'b1) begin n_bad++; $display("FAIL borrow35_borrow got=%b exp=1", br); end
    do_op(8'h00, 8'h01, pulses, done_k, busy_n, d, br, partial);
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL borrow01_diff got=%h exp=ff", d); end
    n_cmp++; if (br !== 1'b1) begin n_bad++; $display("FAIL borrow01_borrow got=%b exp=1", br); end
    n_cmp++; if (partial !== 1'b0) begin n_bad++; $display("FAIL borrow01_partial got=%b exp=0", partial); end
  endtask

  task automatic test_equal;
    int pulses, done_k, busy_n;
    logic [W-1:0] d;
    logic br;
    bit partial;
    do_op(8'hA5, 8'hA5, pulses, done_k, busy_n, d, br, partial);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL equal_diff got=%h exp=00", d); end
    n_cmp++; if (br !== 1'b0) begin n_bad++; $display("FAIL equal_borrow got=%b exp=0", br); end
    n_cmp++; if (busy_n !== 9) begin n_bad++; $display("FAIL equal_busy_cycles got=%0d exp=9", busy_n); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL equal_pulses got=%0d exp=1", pulses); end
  endtask

  // start held for 20 edges: operations accepted at edges 0 and 10 only.
  task automatic test_held_start;
    int pulses, first_k, second_k;
    logic [W-1:0] d1, d2;
    logic br1, br2, busy9;
    pulses = 0; first_k = -1; second_k = -1;
    d1 = '0; d2 = '0; br1 = 1'b0; br2 = 1'b0; busy9 = 1'bx;
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 19) start = 1'b0;
      if (k == 9) begin
        a = 8'hFF;
        b = 8'h01;
        busy9 = busy;
      end else begin
        a = W'($urandom);
        b = W'($urandom);
      end
      if (done === 1'b1) begin
        pulses++;
        if (first_k < 0) begin first_k = k; d1 = diff; br1 = borrow_out; end
        else if (second_k < 0) begin second_k = k; d2 = diff; br2 = borrow_out; end
      end
    end
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL held_pulses got=%0d exp=2", pulses); end
    n_cmp++; if (first_k !== 8) begin n_bad++; $display("FAIL held_first_done got=%0d exp=8", first_k); end
    n_cmp++; if (second_k !== 18) begin n_bad++; $display("FAIL held_second_done got=%0d exp=18", second_k); end
    n_cmp++; if (busy9 !== 1'b0) begin n_bad++; $display("FAIL held_idle_gap got=%b exp=0", busy9); end
    n_cmp++; if (d1 !== 8'hFE || br1 !== 1'b0) begin n_bad++; $display("FAIL held_result1 got=%h/%b exp=fe/0", d1, br1); end
    n_cmp++; if (d2 !== 8'hFE || br2 !== 1'b0) begin n_bad++; $display("FAIL held_result2 got=%h/%b exp=fe/0", d2, br2); end
  endtask

  task automatic test_reset_abort;
    int pulses, busy_n;
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_running got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL abort_diff got=%h exp=00", diff); end
    n_cmp++; if (borrow_out !== 1'b0) begin n_bad++; $display("FAIL abort_borrow got=%b exp=0", borrow_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busy_n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busy_n++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    n_cmp++; if (busy_n !== 0) begin n_bad++; $display("FAIL abort_stays_idle got=%0d exp=0", busy_n); end
  endtask

  task automatic test_random;
    int pulses, done_k, busy_n;
    logic [W-1:0] d, av, bv;
    logic br;
    bit partial;
    logic [W:0] full;
    for (int i = 0; i < 200; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      full = {1'b0, av} - {1'b0, bv};
      do_op(av, bv, pulses, done_k, busy_n, d, br, partial);
      n_cmp++; if (d !== full[W-1:0] || br !== full[W]) begin
        n_bad++; $display("FAIL random_result a=%h b=%h got=%h/%b exp=%h/%b", av, bv, d, br, full[W-1:0], full[W]);
      end
      n_cmp++; if (pulses !== 1 || done_k !== 8) begin
        n_bad++; $display("FAIL random_timing a=%h b=%h got=%0d@%0d exp=1@8", av, bv, pulses, done_k);
      end
    end
  endtask

  // Every (a, b) pair, start held so each lane runs one op per 10 cycles.
  task automatic test_exhaustive;
    logic [15:0] p;
    logic [W:0]  full;
    for (int l = 0; l < LANES; l++) begin
      p = 16'(l);
      xa[l] = p[15:8];
      xb[l] = p[7:0];
    end
    xs = 1'b1;
    for (int j = 0; j < 65536 / LANES; j++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (k == 8) begin
          for (int l = 0; l < LANES; l++) begin
            full = {1'b0, xa[l]} - {1'b0, xb[l]};
            n_cmp++; if (xdone[l] !== 1'b1) begin
              n_bad++; $display("FAIL exh_done lane=%0d op=%0d got=%b exp=1", l, j, xdone[l]);
            end
            n_cmp++; if (xdiff[l] !== full[W-1:0]) begin
              n_bad++; $display("FAIL exh_diff a=%h b=%h got=%h exp=%h", xa[l], xb[l], xdiff[l], full[W-1:0]);
            end
            n_cmp++; if (xbor[l] !== full[W]) begin
              n_bad++; $display("FAIL exh_borrow a=%h b=%h got=%b exp=%b", xa[l], xb[l], xbor[l], full[W]);
            end
          end
        end
        if (k == 9) begin
          if (j == 65536 / LANES - 1) begin
            xs = 1'b0;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              p = 16'((j + 1) * LANES + l);
              xa[l] = p[15:8];
              xb[l] = p[7:0];
            end
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_equal();
    test_held_start();
    test_reset_abort();
    test_random();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
